// File: rtl/spi_rx_fifo.sv
// spi_rx_fifo: receive buffer behind the SPI slave.
// Captures a byte on each rising edge of the slave's done indication into a
// first-word-fall-through FIFO. The FIFO drains through a valid/ready port,
// and a sticky overflow flag records any byte dropped while the FIFO was full.
module spi_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,       // asynchronous, active low
    input  logic [DATA_W-1:0] din,
    input  logic              done_in,
    input  logic              rd_ready,
    input  logic              clr_ovf,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [AW:0]       count,
    output logic              full,
    output logic              empty,
    output logic              overflow
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    // Registered state and next-state values
    logic              done_q;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Control strobes
    logic push_req;
    logic push;
    logic pop;

    // Status comes purely from the registered count, never from pointer compare
    assign empty    = (count_q == '0);
    assign full     = (count_q == DEPTH_C);
    assign rd_valid = ~empty;
    assign count    = count_q;
    assign overflow = overflow_q;
    // Fall-through read: the oldest entry is presented straight from storage
    assign rd_data  = mem_q[rd_ptr_q];

    // A done level held for many cycles produces a single capture request
    assign push_req = done_in & ~done_q;
    assign pop      = rd_valid & rd_ready;
    // When full, a push is only possible if a pop frees a slot in the same cycle
    assign push     = push_req & (~full | pop);

    // Next-state computation for pointers, occupancy and the overflow flag
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Clear first so that a coinciding drop event takes priority
        if (clr_ovf) begin
            overflow_d = 1'b0;
        end
        if (push_req & full & ~pop) begin
            overflow_d = 1'b1;
        end
    end

    // Control state register; done_q resets high so a done level present at
    // reset release is not mistaken for a new byte
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q     <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            done_q     <= done_in;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage write; contents need no reset because occupancy guards reads
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: tb/tb_spi_rx_fifo.sv
// Self-checking bench for spi_rx_fifo: stimulus pushes expected bytes into a
// scoreboard queue, a monitor pops and compares on every accepted read.
module tb_spi_rx_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int AW     = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] din;
    logic              done_in;
    logic              rd_ready;
    logic              clr_ovf;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [AW:0]       count;
    logic              full;
    logic              empty;
    logic              overflow;

    int n_vec = 0;
    int n_err = 0;
    logic [DATA_W-1:0] exp_q[$];

    spi_rx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .done_in  (done_in),
        .rd_ready (rd_ready),
        .clr_ovf  (clr_ovf),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // One done pulse carrying byte d (high one cycle, then low one cycle)
    task automatic pulse(input logic [DATA_W-1:0] d);
        din     = d;
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        tick();
    endtask

    task automatic drain(input int n);
        rd_ready = 1'b1;
        repeat (n) tick();
        rd_ready = 1'b0;
    endtask

    // Monitor: every accepted read is compared against the scoreboard head
    always @(negedge clk) begin
        if (rst === 1'b1 && rd_valid === 1'b1 && rd_ready === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL read_unexpected: got %0h expected no data", rd_data);
            end else begin
                logic [DATA_W-1:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    n_err++;
                    $display("FAIL read_data: got %0h expected %0h", rd_data, e);
                end else begin
                    $display("ok   read_data: %0h", rd_data);
                end
            end
        end
    end

    initial begin
        rst      = 1'b1;
        din      = 8'hAA;
        done_in  = 1'b1;
        rd_ready = 1'b0;
        clr_ovf  = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rst_empty",    32'(empty),    32'd1);
        chk("rst_count",    32'(count),    32'd0);
        chk("rst_full",     32'(full),     32'd0);
        chk("rst_valid",    32'(rd_valid), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        tick();
        tick();
        rst = 1'b1;

        // 1: done_in high across reset release must not capture
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t1_empty", 32'(empty), 32'd1);
            chk("t1_count", 32'(count), 32'd0);
        end
        done_in = 1'b0;
        tick();

        // 2: three pulses then consecutive reads
        pulse(8'h11); exp_q.push_back(8'h11);
        pulse(8'h22); exp_q.push_back(8'h22);
        pulse(8'h33); exp_q.push_back(8'h33);
        chk("t2_count", 32'(count), 32'd3);
        chk("t2_head",  32'(rd_data), 32'h11);
        drain(3);
        chk("t2_empty", 32'(empty), 32'd1);

        // 3: level held ten cycles yields one entry
        din     = 8'h5C;
        done_in = 1'b1;
        repeat (10) tick();
        done_in = 1'b0;
        tick();
        exp_q.push_back(8'h5C);
        chk("t3_count", 32'(count),   32'd1);
        chk("t3_data",  32'(rd_data), 32'h5C);
        drain(1);
        chk("t3_empty", 32'(empty), 32'd1);

        // 4: fill, overflow on a ninth edge, drain, then clear the flag
        for (int i = 0; i < DEPTH; i++) begin
            pulse(8'(i));
            exp_q.push_back(8'(i));
        end
        chk("t4_full",  32'(full),  32'd1);
        chk("t4_count", 32'(count), 32'd8);
        pulse(8'hFF);
        chk("t4_overflow", 32'(overflow), 32'd1);
        chk("t4_count_ovf", 32'(count), 32'd8);
        drain(DEPTH);
        chk("t4_empty", 32'(empty), 32'd1);
        chk("t4_ovf_sticky", 32'(overflow), 32'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("t4_ovf_clr", 32'(overflow), 32'd0);

        // 5: push and pop together while full, exercising pointer wrap
        for (int i = 0; i < DEPTH; i++) begin
            pulse(8'(i));
            exp_q.push_back(8'(i));
        end
        chk("t5_full", 32'(full), 32'd1);
        din      = 8'h08;
        done_in  = 1'b1;
        rd_ready = 1'b1;
        tick();
        exp_q.push_back(8'h08);
        done_in  = 1'b0;
        rd_ready = 1'b0;
        chk("t5_overflow", 32'(overflow), 32'd0);
        chk("t5_count",    32'(count),    32'd8);
        chk("t5_head",     32'(rd_data),  32'h01);
        tick();
        drain(DEPTH);
        chk("t5_empty", 32'(empty), 32'd1);

        // 6: asynchronous reset mid-operation discards stored bytes
        pulse(8'hA1); exp_q.push_back(8'hA1);
        pulse(8'hA2); exp_q.push_back(8'hA2);
        pulse(8'hA3); exp_q.push_back(8'hA3);
        pulse(8'hA4); exp_q.push_back(8'hA4);
        chk("t6_count_pre", 32'(count), 32'd4);
        #2 rst = 1'b0;
        exp_q.delete();
        #1;
        chk("t6_count_rst", 32'(count),    32'd0);
        chk("t6_empty_rst", 32'(empty),    32'd1);
        chk("t6_valid_rst", 32'(rd_valid), 32'd0);
        #2 rst = 1'b1;
        tick();
        pulse(8'h9E); exp_q.push_back(8'h9E);
        chk("t6_count", 32'(count),   32'd1);
        chk("t6_head",  32'(rd_data), 32'h9E);
        drain(1);
        chk("t6_empty", 32'(empty), 32'd1);

        // Underflow guard: rd_ready on an empty FIFO changes nothing
        drain(3);
        chk("uf_count", 32'(count), 32'd0);
        chk("uf_valid", 32'(rd_valid), 32'd0);

        chk("scoreboard_left", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_rx_fifo.md
Name: spi_rx_fifo

Overview:
- Receive buffer directly downstream of the SPI slave inside top.
- Captures each byte the slave presents on its parallel output when the slave's done indication rises, and stores it in a first-word-fall-through FIFO.
- Drains the FIFO through a valid/ready read port, decoupling the SPI byte rate from the consumer.
- Flags lost bytes with a sticky overflow bit.

Parameters:
DATA_W, 8, width of one received word (matches the slave dout width)
DEPTH, 8, number of FIFO entries; power of two, >= 2; AW = log2(DEPTH) is derived internally

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
din  input  DATA_W  received byte from the SPI slave (its dout)
done_in  input  1  slave done indication; may be a pulse or a held level
rd_ready  input  1  consumer accepts rd_data this cycle
clr_ovf  input  1  synchronous clear of the overflow flag
rd_valid  output  1  FIFO non-empty; rd_data is valid
rd_data  output  DATA_W  oldest stored byte (first-word-fall-through)
count  output  AW+1  number of stored entries, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
overflow  output  1  sticky; a byte was dropped because the FIFO was full

Behaviour:
- Reset (rst low, asynchronous) clears all state:
  - read/write pointers and count = 0
  - overflow = 0
  - done_q = 1, so a done_in already high at reset release is not captured
- Outputs during reset: rd_valid = 0, empty = 1, full = 0, count = 0, overflow = 0. rd_data is don't-care.
- Reset mid-operation discards all stored bytes; an in-flight edge is lost.
- Edge detect:
  - done_q <= done_in every cycle.
  - push_req = done_in & ~done_q.
  - A level held high for N cycles yields exactly one push.
- Pop: pop = rd_valid & rd_ready.
- Push: push = push_req & (~full | pop). On push, mem[wr_ptr] <= din and wr_ptr increments.
- Capture timing: din is sampled in the same cycle push_req is high.
- Latency: byte appears on rd_data with rd_valid = 1 one cycle after the capture edge. rd_data is driven from mem[rd_ptr]; no output register.
- Pointers are AW bits and wrap from DEPTH-1 to 0. full/empty come from count, not from pointer compare.
- count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
- Full with push_req and pop in the same cycle: the push is accepted, the oldest byte leaves, count stays DEPTH, overflow is not set.
- Full with push_req and no pop: byte dropped, overflow <= 1, FIFO contents unchanged.
- Empty with rd_ready high: no pop, count stays 0, pointers unchanged (no underflow).
- An empty FIFO cannot push-and-pop in one cycle: rd_valid is 0 that cycle.
- overflow clear: clr_ovf = 1 clears it on the next edge. If a new overflow event coincides with clr_ovf, the set wins (overflow = 1).
- No internal FSM beyond the edge detector. The controller is pure counter/pointer logic; all outputs derive from registered state.

Test Plan:
1. Reset release with done_in held high, din = 8'hAA -> no capture; empty = 1, count = 0 for 5 cycles.
2. Three done_in pulses with din = 8'h11, 8'h22, 8'h33, rd_ready = 0 -> count = 3. Then rd_ready = 1 -> rd_data reads 11, 22, 33 on consecutive cycles, after which empty = 1.
3. done_in held high for 10 cycles with din = 8'h5C -> exactly one entry (count = 1, rd_data = 8'h5C).
4. Fill DEPTH = 8 with 8'h00..8'h07 (full = 1), then a ninth edge with din = 8'hFF and rd_ready = 0 -> overflow = 1, count = 8, reads return 00..07. Then pulse clr_ovf -> overflow = 0.
5. FIFO full holding 00..07, ninth edge (din = 8'h08) coincident with rd_ready = 1 -> overflow stays 0, count stays 8, subsequent reads return 01..08 (checks pointer wrap).
6. Store 4 bytes, assert rst low asynchronously between clock edges -> count = 0, empty = 1 immediately. After release, a new byte 8'h9E is read back first.
